// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, grant and command encodings for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } gnt_e;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - imem, dmem and downstream memory port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
);

  logic [p_ADDR_BITS-1:0] imem_addr;
  logic [1:0]             imem_size;
  logic                   imem_valid;
  logic                   imem_ready;
  logic                   imem_r_valid;
  logic                   imem_r_ready;
  logic [p_DATA_BITS-1:0] imem_r_data;

  logic [p_ADDR_BITS-1:0] dmem_addr;
  logic                   dmem_cmd;
  logic [1:0]             dmem_size;
  logic                   dmem_valid;
  logic                   dmem_ready;
  logic                   dmem_r_valid;
  logic                   dmem_r_ready;
  logic [p_DATA_BITS-1:0] dmem_r_data;
  logic                   dmem_w_valid;
  logic                   dmem_w_ready;
  logic [p_STRB_BITS-1:0] dmem_w_strb;
  logic [p_DATA_BITS-1:0] dmem_w_data;

  logic [p_ADDR_BITS-1:0] mem_addr;
  logic                   mem_cmd;
  logic [1:0]             mem_size;
  logic                   mem_valid;
  logic                   mem_ready;
  logic                   mem_r_valid;
  logic                   mem_r_ready;
  logic [p_DATA_BITS-1:0] mem_r_data;
  logic                   mem_w_valid;
  logic                   mem_w_ready;
  logic [p_STRB_BITS-1:0] mem_w_strb;
  logic [p_DATA_BITS-1:0] mem_w_data;

  // Arbiter view
  modport slave (
    input  imem_addr, imem_size, imem_valid, imem_r_ready,
    output imem_ready, imem_r_valid, imem_r_data,
    input  dmem_addr, dmem_cmd, dmem_size, dmem_valid, dmem_r_ready,
    input  dmem_w_valid, dmem_w_strb, dmem_w_data,
    output dmem_ready, dmem_r_valid, dmem_r_data, dmem_w_ready,
    output mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready,
    output mem_w_valid, mem_w_strb, mem_w_data,
    input  mem_ready, mem_r_valid, mem_r_data, mem_w_ready
  );

  // Core and memory controller view
  modport master (
    output imem_addr, imem_size, imem_valid, imem_r_ready,
    input  imem_ready, imem_r_valid, imem_r_data,
    output dmem_addr, dmem_cmd, dmem_size, dmem_valid, dmem_r_ready,
    output dmem_w_valid, dmem_w_strb, dmem_w_data,
    input  dmem_ready, dmem_r_valid, dmem_r_data, dmem_w_ready,
    input  mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready,
    input  mem_w_valid, mem_w_strb, mem_w_data,
    output mem_ready, mem_r_valid, mem_r_data, mem_w_ready
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select; MEM_ARB_RR_EN selects round-robin, else dmem-first priority
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic elig_imem,
  input  logic elig_dmem,
  input  gnt_e last_gnt,
  output logic any,
  output gnt_e win
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    any = elig_imem | elig_dmem;
    win = GNT_IMEM;
    if (elig_imem && elig_dmem)
      win = (last_gnt == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
    else if (elig_dmem)
      win = GNT_DMEM;
  end
`else
  gnt_e unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    any = elig_imem | elig_dmem;
    win = elig_dmem ? GNT_DMEM : GNT_IMEM;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - imem/dmem to single memory port arbiter, one transaction at a time
// Arbitration policy set by MEM_ARB_RR_EN inside mem_arb_pick.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_e                 state;
  gnt_e                   gnt;
  gnt_e                   last_gnt;
  gnt_e                   win;
  logic                   any;
  logic                   elig_imem;
  logic                   elig_dmem;
  logic                   grant;
  logic                   r_ready;
  logic                   cmd_done;

  logic [p_ADDR_BITS-1:0] addr_q;
  logic                   cmd_q;
  logic [1:0]             size_q;
  logic [p_STRB_BITS-1:0] strb_q;
  logic [p_DATA_BITS-1:0] data_q;
  logic                   valid_q;
  logic                   w_valid_q;

  // A dmem write is only eligible once its data is present, so it never blocks imem.
  assign elig_imem = bus.imem_valid;
  assign elig_dmem = bus.dmem_valid && (bus.dmem_cmd == CMD_RD || bus.dmem_w_valid);

  mem_arb_pick u_pick (
    .elig_imem (elig_imem),
    .elig_dmem (elig_dmem),
    .last_gnt  (last_gnt),
    .any       (any),
    .win       (win)
  );

  // rst gates the combinational readies so nothing is accepted while held in reset.
  assign grant            = rst && (state == IDLE) && any;
  assign bus.imem_ready   = grant && (win == GNT_IMEM);
  assign bus.dmem_ready   = grant && (win == GNT_DMEM);
  assign bus.dmem_w_ready = bus.dmem_ready && (bus.dmem_cmd == CMD_WR);

  assign r_ready           = (state == RDATA) &&
                             ((gnt == GNT_IMEM) ? bus.imem_r_ready : bus.dmem_r_ready);
  assign bus.mem_r_ready   = r_ready;
  assign bus.imem_r_valid  = (state == RDATA) && (gnt == GNT_IMEM) && bus.mem_r_valid;
  assign bus.dmem_r_valid  = (state == RDATA) && (gnt == GNT_DMEM) && bus.mem_r_valid;
  assign bus.imem_r_data   = bus.mem_r_data;
  assign bus.dmem_r_data   = bus.mem_r_data;

  assign bus.mem_addr    = addr_q;
  assign bus.mem_cmd     = cmd_q;
  assign bus.mem_size    = size_q;
  assign bus.mem_w_strb  = strb_q;
  assign bus.mem_w_data  = data_q;
  assign bus.mem_valid   = valid_q;
  assign bus.mem_w_valid = w_valid_q;

  assign cmd_done = bus.mem_ready && (cmd_q == CMD_RD || bus.mem_w_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= GNT_IMEM;
      last_gnt  <= GNT_IMEM;
      addr_q    <= '0;
      cmd_q     <= CMD_RD;
      size_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      w_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state    <= ISSUE;
            gnt      <= win;
            last_gnt <= win;
            valid_q  <= 1'b1;
            if (win == GNT_DMEM) begin
              addr_q    <= bus.dmem_addr;
              cmd_q     <= bus.dmem_cmd;
              size_q    <= bus.dmem_size;
              strb_q    <= (bus.dmem_cmd == CMD_WR) ? bus.dmem_w_strb : '0;
              data_q    <= (bus.dmem_cmd == CMD_WR) ? bus.dmem_w_data : '0;
              w_valid_q <= (bus.dmem_cmd == CMD_WR);
            end else begin
              addr_q    <= bus.imem_addr;
              cmd_q     <= CMD_RD;
              size_q    <= bus.imem_size;
              strb_q    <= '0;
              data_q    <= '0;
              w_valid_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (cmd_done) begin
            valid_q   <= 1'b0;
            w_valid_q <= 1'b0;
            state     <= (cmd_q == CMD_WR) ? IDLE : RDATA;
          end
        end
        RDATA: begin
          if (bus.mem_r_valid && r_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_arbiter_if #(.p_ADDR_BITS(32), .p_DATA_BITS(32), .p_STRB_BITS(4)) bus ();

  mem_arbiter #(.p_ADDR_BITS(32), .p_DATA_BITS(32), .p_STRB_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_d;

  initial begin
    errors = 0;
    checks = 0;
`ifdef MEM_ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    rst = 1'b0;
    bus.imem_addr = '0; bus.imem_size = '0; bus.imem_valid = 1'b1; bus.imem_r_ready = 1'b0;
    bus.dmem_addr = '0; bus.dmem_cmd = 1'b0; bus.dmem_size = '0; bus.dmem_valid = 1'b1;
    bus.dmem_r_ready = 1'b0; bus.dmem_w_valid = 1'b0; bus.dmem_w_strb = '0; bus.dmem_w_data = '0;
    bus.mem_ready = 1'b0; bus.mem_r_valid = 1'b0; bus.mem_r_data = '0; bus.mem_w_ready = 1'b0;

    // Reset with requests present
    tick(); tick();
    chk("rst_readies", {bus.imem_ready, bus.dmem_ready, bus.dmem_w_ready}, 3'b000);
    chk("rst_mem_valid", {bus.mem_valid, bus.mem_w_valid, bus.mem_r_ready}, 3'b000);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
    rst = 1'b1;
    tick();

    // imem read 0x100
    bus.mem_ready = 1'b1; bus.mem_w_ready = 1'b1;
    bus.imem_valid = 1'b1; bus.imem_addr = 32'h100; bus.imem_size = 2'd2;
    #1;
    chk("t1_ready", {bus.imem_ready, bus.dmem_ready}, 2'b10);
    tick();
    bus.imem_valid = 1'b0;
    #1;
    chk("t1_mem_valid", bus.mem_valid, 1'b1);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_cmd_size", {bus.mem_cmd, bus.mem_size, bus.mem_w_valid}, 4'b0100);
    chk("t1_ready_busy", bus.imem_ready, 1'b0);
    tick();
    bus.mem_r_valid = 1'b1; bus.mem_r_data = 32'hDEADBEEF; bus.imem_r_ready = 1'b1;
    #1;
    chk("t1_r_valid", {bus.imem_r_valid, bus.dmem_r_valid}, 2'b10);
    chk("t1_r_data", bus.imem_r_data, 32'hDEADBEEF);
    chk("t1_r_ready", {bus.mem_r_ready, bus.mem_valid}, 2'b10);
    tick();
    bus.mem_r_valid = 1'b0; bus.imem_r_ready = 1'b0;
    #1;
    chk("t1_done", {bus.imem_r_valid, bus.mem_r_ready}, 2'b00);

    // dmem write 0x200
    bus.dmem_valid = 1'b1; bus.dmem_cmd = 1'b1; bus.dmem_addr = 32'h200; bus.dmem_size = 2'd2;
    bus.dmem_w_valid = 1'b1; bus.dmem_w_strb = 4'hF; bus.dmem_w_data = 32'h12345678;
    #1;
    chk("t2_ready", {bus.imem_ready, bus.dmem_ready, bus.dmem_w_ready}, 3'b011);
    tick();
    bus.dmem_valid = 1'b0; bus.dmem_w_valid = 1'b0;
    #1;
    chk("t2_valids", {bus.mem_valid, bus.mem_w_valid, bus.mem_cmd}, 3'b111);
    chk("t2_addr", bus.mem_addr, 32'h200);
    chk("t2_strb", bus.mem_w_strb, 4'hF);
    chk("t2_data", bus.mem_w_data, 32'h12345678);
    tick();
    chk("t2_idle", {bus.mem_valid, bus.mem_w_valid, bus.mem_r_ready}, 3'b000);
    bus.imem_valid = 1'b1;
    #1;
    chk("t2_idle_grant", bus.imem_ready, 1'b1);
    bus.imem_valid = 1'b0;

    // Reset so the contention sequence starts from last_gnt = imem
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Contention: four back-to-back reads
    bus.imem_valid = 1'b1; bus.imem_addr = 32'h400;
    bus.dmem_valid = 1'b1; bus.dmem_cmd = 1'b0; bus.dmem_addr = 32'h800;
    bus.imem_r_ready = 1'b1; bus.dmem_r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_grant%0d", i), {bus.imem_ready, bus.dmem_ready},
          exp_d[i] ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("t3_addr%0d", i), bus.mem_addr, exp_d[i] ? 32'h800 : 32'h400);
      tick();
      bus.mem_r_valid = 1'b1; bus.mem_r_data = 32'(i);
      #1;
      chk($sformatf("t3_route%0d", i), {bus.imem_r_valid, bus.dmem_r_valid},
          exp_d[i] ? 2'b01 : 2'b10);
      tick();
      bus.mem_r_valid = 1'b0;
    end
    bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
    bus.imem_r_ready = 1'b0; bus.dmem_r_ready = 1'b0;
    tick();

    // Ineligible dmem write does not block imem
    bus.dmem_valid = 1'b1; bus.dmem_cmd = 1'b1; bus.dmem_w_valid = 1'b0;
    bus.dmem_addr = 32'h300; bus.dmem_w_data = 32'hA5A5A5A5; bus.dmem_w_strb = 4'h3;
    bus.imem_valid = 1'b1; bus.imem_addr = 32'h104;
    #1;
    chk("t4_imem_wins", {bus.imem_ready, bus.dmem_ready, bus.dmem_w_ready}, 3'b100);
    tick();
    bus.imem_valid = 1'b0;
    #1;
    chk("t4_busy", {bus.imem_ready, bus.dmem_ready}, 2'b00);
    tick();
    bus.mem_r_valid = 1'b1; bus.imem_r_ready = 1'b1;
    tick();
    bus.mem_r_valid = 1'b0; bus.imem_r_ready = 1'b0;
    #1;
    chk("t4_wait_wvalid", bus.dmem_ready, 1'b0);
    bus.dmem_w_valid = 1'b1;
    #1;
    chk("t4_w_granted", {bus.dmem_ready, bus.dmem_w_ready}, 2'b11);

    // Accept that write, then stall downstream for 5 cycles
    bus.mem_ready = 1'b0;
    tick();
    bus.dmem_valid = 1'b0; bus.dmem_w_valid = 1'b0;
    bus.dmem_addr = 32'h999; bus.dmem_w_data = 32'h0; bus.imem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t5_addr%0d", i), bus.mem_addr, 32'h300);
      chk($sformatf("t5_data%0d", i), bus.mem_w_data, 32'hA5A5A5A5);
      chk($sformatf("t5_ctl%0d", i),
          {bus.mem_valid, bus.mem_w_valid, bus.mem_cmd, bus.mem_w_strb}, 7'b1110011);
      chk($sformatf("t5_rdy%0d", i), {bus.imem_ready, bus.dmem_ready}, 2'b00);
      tick();
    end
    bus.imem_valid = 1'b0; bus.mem_ready = 1'b1;
    tick();
    chk("t5_release", {bus.mem_valid, bus.mem_w_valid}, 2'b00);

    // Reset in RDATA, late mem_r_valid ignored
    bus.imem_valid = 1'b1; bus.imem_addr = 32'h108;
    tick();
    bus.imem_valid = 1'b0;
    tick();
    bus.imem_r_ready = 1'b1; bus.imem_valid = 1'b1;
    #1;
    chk("t6_in_rdata", bus.mem_r_ready, 1'b1);
    rst = 1'b0;
    #1;
    chk("t6_rst_outs", {bus.mem_valid, bus.mem_r_ready, bus.imem_r_valid,
                        bus.dmem_r_valid, bus.imem_ready, bus.dmem_ready}, 6'b000000);
    chk("t6_rst_addr", bus.mem_addr, 32'h0);
    tick();
    bus.imem_valid = 1'b0; bus.mem_r_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_late_rvalid", {bus.imem_r_valid, bus.dmem_r_valid, bus.mem_r_ready}, 3'b000);
    tick();
    chk("t6_still_idle", {bus.imem_r_valid, bus.mem_valid}, 2'b00);
    bus.mem_r_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
